// File: rtl/alu_mul_seq_if.sv
// Handshake and external add/sub slice bundle for the sequential 4x4 multiplier.
interface alu_mul_seq_if;
  logic       start;
  logic [3:0] mcand;
  logic [3:0] mplier;
  logic       alu_ctrl;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_s;
  logic       alu_co;
  logic       busy;
  logic       done;
  logic [7:0] product;

  modport slave (
    input  start, mcand, mplier, alu_s, alu_co,
    output alu_ctrl, alu_a, alu_b, busy, done, product
  );

  modport master (
    output start, mcand, mplier, alu_s, alu_co,
    input  alu_ctrl, alu_a, alu_b, busy, done, product
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add 4x4 unsigned multiplier driving an external 4-bit adder slice.
// Optional zero-operand shortcut: define ALU_MUL_SEQ_EARLY_EXIT_EN.
module alu_mul_seq (
  input  logic           clk,
  input  logic           rst,
  alu_mul_seq_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic [3:0] r_m;
  logic [3:0] r_phi;
  logic [3:0] r_q;
  logic [1:0] r_cnt;
  logic [7:0] r_product;
  logic [7:0] w_next_pq;
  logic       w_accept;

  // Carry lands in the top bit of the shifted pair, so it is never dropped.
  assign w_next_pq = {bus.alu_co, bus.alu_s, r_q[3:1]};
  assign w_accept  = bus.start && (r_state != S_RUN);

  assign bus.alu_ctrl = 1'b0;
  assign bus.alu_a    = r_phi;
  assign bus.alu_b    = r_q[0] ? r_m : 4'h0;
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.product  = r_product;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  logic w_zero_op;
  assign w_zero_op = (bus.mcand == 4'h0) || (bus.mplier == 4'h0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m       <= 4'h0;
      r_phi     <= 4'h0;
      r_q       <= 4'h0;
      r_cnt     <= 2'd0;
      r_product <= 8'h00;
    end else if (w_accept) begin
      r_m   <= bus.mcand;
      r_q   <= bus.mplier;
      r_phi <= 4'h0;
      r_cnt <= 2'd0;
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
      if (w_zero_op) begin
        r_state   <= S_DONE;
        r_product <= 8'h00;
      end else begin
        r_state <= S_RUN;
      end
`else
      r_state <= S_RUN;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          {r_phi, r_q} <= w_next_pq;
          r_cnt        <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state   <= S_DONE;
            r_product <= w_next_pq;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL have no parameters; all widths are fixed at 4-bit operands and an 8-bit product.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request: begin a multiply; sampled only when not busy.
REQ-006 mcand  input  4  unsigned multiplicand, captured on an accepted start.
REQ-007 mplier  input  4  unsigned multiplier, captured on an accepted start.
REQ-008 alu_ctrl  output  1  add/sub select to the external 4-bit add/sub slice; 0 means add.
REQ-009 alu_a  output  4  external slice operand A.
REQ-010 alu_b  output  4  external slice operand B.
REQ-011 alu_s  input  4  external slice sum, combinational from alu_a/alu_b/alu_ctrl.
REQ-012 alu_co  input  1  external slice carry-out.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse: product valid.
REQ-015 product  output  8  unsigned mcand*mplier; held from done until the next accepted start.

Function
REQ-016 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE with state register, internal regs M[3:0], P_hi[3:0], Q[3:0] and cnt[1:0].
REQ-017 alu_ctrl SHALL be constant 0, so the slice carry-in is 0 and it always adds.
REQ-018 alu_a SHALL equal P_hi; alu_b SHALL equal M when Q[0]=1, else 4'h0; both are registered-state driven, with no combinational path from start.
REQ-019 Start accept: start=1 in IDLE or DONE SHALL load M<=mcand, Q<=mplier, P_hi<=0, cnt<=0 and go to RUN.
REQ-020 Each RUN cycle SHALL update {P_hi,Q} <= {alu_co, alu_s, Q[3:1]}, i.e. (carry,sum,Q) shifted right by 1, and cnt <= cnt+1.
REQ-021 RUN SHALL last exactly 4 cycles, leaving when cnt=3 at that edge and going to DONE.
REQ-022 On entering DONE, product SHALL be loaded with {P_hi,Q} as computed on that edge; done=1 for exactly the DONE cycle.
REQ-023 Latency: start sampled at edge k -> busy high for cycles k+1..k+4 -> done high in cycle k+5.
REQ-024 start while in RUN SHALL be ignored, with no effect on operands, count or result.
REQ-025 start in the DONE cycle SHALL be accepted (REQ-019), allowing back-to-back operations with one-cycle spacing; done still pulses for the finishing operation.
REQ-026 product SHALL NOT change except on entry to DONE or on reset.
REQ-027 alu_co SHALL never be lost: the 4-bit partial sum plus carry always fits the {P_hi,Q} shift.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, with busy=0, done=0, product=8'h00, M=P_hi=Q=0 and cnt=0.
REQ-029 Reset SHALL take priority over start and over any in-progress RUN; an aborted operation SHALL produce no done pulse.

Configuration
REQ-030 With macro ALU_MUL_SEQ_EARLY_EXIT_EN defined, an accepted start with mcand==0 or mplier==0 SHALL go directly to DONE on the same edge with product<=8'h00, giving done in cycle k+1 and no busy.
REQ-031 Without ALU_MUL_SEQ_EARLY_EXIT_EN, zero operands SHALL follow the normal 4-cycle RUN path (latency per REQ-023), still yielding 8'h00.

Verification
REQ-032 Bench SHALL cover: mcand=4'hF, mplier=4'hF, start at edge k -> busy cycles k+1..k+4, done in k+5, product=8'hE1, alu_ctrl=0 throughout.
REQ-033 Bench SHALL cover: mcand=4'h9, mplier=4'h0 -> product=8'h00, with done in k+1 if EARLY_EXIT_EN is defined, else in k+5.
REQ-034 Bench SHALL cover: 6*5, with start pulsed again (3*3) during RUN cycle 2 -> only product=8'h1E, a single done, and the second start ignored.
REQ-035 Bench SHALL cover: 7*3 then start 2*4 in the DONE cycle -> done shows 8'h15; the next done 5 cycles later shows 8'h08.
REQ-036 Bench SHALL cover: 12*11 with rst asserted in RUN cycle 3 -> next cycle IDLE, product=8'h00, and no done pulse.
REQ-037 Bench SHALL cover: an exhaustive 256-pair sweep against a reference model, checking product==mcand*mplier and exactly one done per accepted start.
